// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer and its matching receiver:
// FSM states, the legal word-length range and the bit-counter width helper.
package piso_pkg;

  // Transmitter FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Legal range of the word length parameter
  localparam int PISO_WIDTH_MIN = 2;
  localparam int PISO_WIDTH_MAX = 32;

  // Width of a counter that indexes bits 0..width-1 of a word
  function automatic int piso_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer. Accepts a word over a valid/ready
// load handshake and shifts it out LSB first, one bit per accepted beat.
// The next word can be loaded on the final beat so frames run back-to-back.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_input,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_output,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = piso_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Reject word lengths outside the supported range at elaboration
  if ((WIDTH < PISO_WIDTH_MIN) || (WIDTH > PISO_WIDTH_MAX)) begin : g_width_check
    $error("piso_serializer: WIDTH out of supported range");
  end

  piso_state_t      state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] bit_cnt, cnt_next;
  logic             last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  // State, shifter and bit counter; reset aborts any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
    end
  end

  // Next-state logic and the handshake-dependent load_ready decode
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    cnt_next   = bit_cnt;
    load_ready = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shift_next = parallel_input;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        load_ready = last_bit && serial_ready;
        if (serial_ready) begin
          if (!last_bit) begin
            shift_next = shift_reg >> 1;
            cnt_next   = bit_cnt + CNT_W'(1);
          end else if (load_valid) begin
            shift_next = parallel_input;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Serial-side outputs decoded purely from registered state
  always_comb begin
    busy          = (state == SHIFT);
    serial_valid  = (state == SHIFT);
    serial_output = (state == SHIFT) && shift_reg[0];
    frame_start   = (state == SHIFT) && (bit_cnt == '0);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: a bit-index model of the frame
// is checked against the DUT every cycle, a behavioural MSB-fill receiver
// reassembles each frame, and directed scenarios pin literal expectations.
module tb_piso_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] parallel_input;
  logic             load_valid;
  logic             load_ready;
  logic             serial_output;
  logic             serial_valid;
  logic             serial_ready;
  logic             frame_start;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // Model: word in flight, index of the bit being presented, frame active
  logic [WIDTH-1:0] m_word;
  int               m_pos;
  logic             m_active;

  // Observation counters written only by the compare process
  logic             stream_q[$];
  int               valid_cnt = 0;
  int               fs_cnt    = 0;
  int               ones_cnt  = 0;
  int               rx_checks = 0;
  logic [WIDTH-1:0] rx_word   = '0;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .parallel_input(parallel_input),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .serial_output (serial_output),
    .serial_valid  (serial_valid),
    .serial_ready  (serial_ready),
    .frame_start   (frame_start),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lv, input logic [WIDTH-1:0] word, input logic sr);
    load_valid     = lv;
    parallel_input = word;
    serial_ready   = sr;
    tick();
  endtask

  function automatic logic model_load_ready();
    return !m_active || ((m_pos == WIDTH - 1) && serial_ready);
  endfunction

  function automatic logic [31:0] stream_word(input int start, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i] = stream_q[start + i];
    return w;
  endfunction

  // Frame-level model: a load starts a frame at bit 0, each beat advances one bit
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_word   <= '0;
    end else begin
      if (load_valid && model_load_ready()) begin
        m_word   <= parallel_input;
        m_pos    <= 0;
        m_active <= 1'b1;
      end else if (m_active && serial_ready) begin
        if (m_pos == WIDTH - 1) m_active <= 1'b0;
        else m_pos <= m_pos + 1;
      end
    end
  end

  // Compare every output mid-cycle and run the loopback receiver
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("serial_valid", 32'(serial_valid), 32'(m_active));
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("serial_output", 32'(serial_output), m_active ? 32'(m_word[m_pos]) : 32'd0);
      checkOutput("frame_start", 32'(frame_start), 32'(m_active && (m_pos == 0)));
      checkOutput("load_ready", 32'(load_ready), 32'(model_load_ready()));
      if (serial_valid) valid_cnt++;
      if (frame_start) fs_cnt++;
      if (serial_valid && serial_output) ones_cnt++;
      if (serial_valid && serial_ready) begin
        stream_q.push_back(serial_output);
        rx_word = {serial_output, rx_word[WIDTH-1:1]};
        if (m_active && (m_pos == WIDTH - 1)) begin
          rx_checks++;
          checkOutput("loopback_word", 32'(rx_word), 32'(m_word));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, v, f, o, r, n;
    logic [WIDTH-1:0] w;

    reset = 1'b1; load_valid = 1'b0; parallel_input = '0; serial_ready = 1'b0;
    #1;
    checkOutput("reset_load_ready", 32'(load_ready), 32'd1);
    checkOutput("reset_serial_valid", 32'(serial_valid), 32'd0);
    checkOutput("reset_serial_output", 32'(serial_output), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Single frame of 8'hA5
    s = stream_q.size(); v = valid_cnt; f = fs_cnt;
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkOutput("a5_first_frame_start", 32'(frame_start), 32'd1);
    checkOutput("a5_first_bit", 32'(serial_output), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("a5_end_busy", 32'(busy), 32'd0);
    checkOutput("a5_end_load_ready", 32'(load_ready), 32'd1);
    checkOutput("a5_bits", stream_word(s, 8), 32'h000000A5);
    checkOutput("a5_valid_cycles", 32'(valid_cnt - v), 32'd8);
    checkOutput("a5_frame_starts", 32'(fs_cnt - f), 32'd1);

    // Back-to-back FF then 00
    s = stream_q.size(); v = valid_cnt; f = fs_cnt;
    applyStimulus(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    load_valid = 1'b1; parallel_input = 8'h00; #1;
    checkOutput("b2b_last_load_ready", 32'(load_ready), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("b2b_bits", stream_word(s, 16), 32'h000000FF);
    checkOutput("b2b_valid_cycles", 32'(valid_cnt - v), 32'd16);
    checkOutput("b2b_frame_starts", 32'(fs_cnt - f), 32'd2);
    checkOutput("b2b_end_busy", 32'(busy), 32'd0);

    // Stall of 3 cycles on bit 0 of 8'h01
    s = stream_q.size(); v = valid_cnt; o = ones_cnt;
    applyStimulus(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stall_frame_cycles", 32'(valid_cnt - v), 32'd11);
    checkOutput("stall_ones_cycles", 32'(ones_cnt - o), 32'd4);
    checkOutput("stall_bits", stream_word(s, 8), 32'h00000001);

    // Load attempts blocked mid-frame, accepted at the last-bit beat
    s = stream_q.size();
    applyStimulus(1'b1, 8'h5A, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1; parallel_input = 8'h3C; serial_ready = 1'b1; #1;
      checkOutput("blocked_load_ready", 32'(load_ready), 32'd0);
      tick();
    end
    checkOutput("blocked_last_load_ready", 32'(load_ready), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("blocked_bits", stream_word(s, 16), 32'h00003C5A);

    // Asynchronous reset during bit 4 of 8'hC3
    applyStimulus(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_serial_valid", 32'(serial_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_serial_output", 32'(serial_output), 32'd0);
    checkOutput("midreset_load_ready", 32'(load_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    s = stream_q.size();
    applyStimulus(1'b1, 8'h81, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postreset_bits", stream_word(s, 8), 32'h00000081);

    // Loopback of random words with random downstream stalls
    r = rx_checks;
    for (int k = 0; k < 6; k++) begin
      w = WIDTH'($urandom);
      applyStimulus(1'b1, w, 1'b1);
      n = 0;
      while (m_active && n < 64) begin
        applyStimulus(1'b0, 8'h00, ($urandom_range(0, 3) != 0));
        n++;
      end
      if (n >= 64) checkOutput("loopback_timeout", 32'(n), 32'd0);
    end
    checkOutput("loopback_frames", 32'(rx_checks - r), 32'd6);
    checkOutput("loopback_end_busy", 32'(busy), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer; the transmit end of the serial-to-parallel shift-register link. Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per accepted serial beat, LSB first. A downstream shift-register receiver that fills from its MSB end therefore reassembles the word in its original bit order. Sits between the word-level datapath and the single-wire serial link; downstream pacing is via serial_ready.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- parallel_input  input  WIDTH  word to transmit; sampled only on a load handshake.
- load_valid  input  1  upstream has a word on parallel_input.
- load_ready  output  1  block can accept a word this cycle.
- serial_output  output  1  current serial bit.
- serial_valid  output  1  serial_output carries a frame bit.
- serial_ready  input  1  downstream consumes the current bit at this edge.
- frame_start  output  1  high while bit 0 of a frame is presented.
- busy  output  1  a frame is in progress (state SHIFT).

## Operation
- States: IDLE, SHIFT.
- Internal registers:
  - shift_reg[WIDTH-1:0].
  - bit_cnt, width $clog2(WIDTH), counting bits consumed in the current frame.
- Load handshake: a load occurs at any edge where load_valid && load_ready.
- Beat: an edge in SHIFT where serial_ready = 1.
- IDLE:
  - load_ready = 1; serial_valid = 0; serial_output = 0.
  - On load: shift_reg <= parallel_input, bit_cnt <= 0, go to SHIFT.
- SHIFT:
  - serial_output = shift_reg[0]; serial_valid = 1; frame_start = (bit_cnt == 0).
  - On a beat with bit_cnt < WIDTH-1: shift_reg <= shift_reg >> 1 (zero fill), bit_cnt increments.
  - Without a beat: all state holds and the bit stays presented (stall of any length).
  - Last bit (bit_cnt == WIDTH-1): load_ready = serial_ready (combinational).
  - Beat on the last bit with a load: reload shift_reg, bit_cnt <= 0, stay in SHIFT. Frames run back-to-back with no idle cycle.
  - Beat on the last bit without a load: go to IDLE.
- load_ready is 0 in SHIFT except in the last-bit case above. parallel_input is ignored outside a load.
- Outputs are registered or decoded from registered state, apart from the load_ready/serial_ready path.
- Reset values: state IDLE, shift_reg 0, bit_cnt 0. Outputs: load_ready 1, serial_output 0, serial_valid 0, frame_start 0, busy 0.
- Reset mid-frame: the frame is aborted immediately (asynchronously) and no partial frame resumes. The first edge after reset deasserts may accept a load.
- The bit order is fixed: LSB first, with no parameter to change it.

## Timing
- Load at edge N: bit 0 is presented in cycle N+1, with frame_start = 1.
- With serial_ready held high, bits 0..WIDTH-1 occupy cycles N+1..N+WIDTH. busy returns to 0 in cycle N+WIDTH+1, unless a reload occurred.
- Back-to-back throughput: one bit per cycle sustained, and serial_valid never drops between frames.
- Each stall cycle on serial_ready extends the frame by exactly one cycle.
- Latency from load to first bit: 1 cycle.

## Structure
- Package piso_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the WIDTH legal-range constants;
  - the function for bit_cnt width.
- Single module with no sub-module. The counter and shifter are small enough to stay inline.
- A shared package lets the receiver side use the same width constants.

## Test plan
- Single frame: WIDTH = 8, load 8'hA5, serial_ready = 1.
  - Expect serial bits 1,0,1,0,0,1,0,1 in cycles 1..8.
  - Expect frame_start only in cycle 1; busy 0 and load_ready 1 in cycle 9.
- Back-to-back: load 8'hFF, with load_valid held and 8'h00 on parallel_input during the last bit.
  - Expect 8 ones then 8 zeros, with serial_valid continuously 1.
  - Expect frame_start in cycles 1 and 9.
- Stall: load 8'h01, then drop serial_ready for 3 cycles while bit 0 is presented.
  - Expect serial_output held at 1 for 4 cycles, then seven 0s.
  - Expect the frame to last 11 cycles.
- Load blocked: hold load_valid = 1 with 8'h3C during cycles 2..7 of a frame.
  - Expect load_ready = 0 throughout and the current frame unaffected.
  - Expect the word accepted only at the last-bit beat.
- Reset mid-frame: assert reset during bit 4 of 8'hC3.
  - Expect serial_valid, busy and serial_output to go to 0 without waiting for a clock edge.
  - After release, a load of 8'h81 transmits 1,0,0,0,0,0,0,1.
- Loopback: connect to the shift-register receiver (WIDTH = 8) and send random words.
  - Expect the receiver's parallel word to equal the transmitted word after each frame.
